// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, instruction field positions and
// the fetch/issue state encoding, kept in one place for fetch and control.
package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_LW   = 4'b0001;
  localparam logic [3:0] OP_SW   = 4'b0010;
  localparam logic [3:0] OP_SUBI = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1111;

  // Fixed 16-bit format: opcode | rs | rt | imm/rd
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RS_MSB  = 11;
  localparam int RS_LSB  = 8;
  localparam int RT_MSB  = 7;
  localparam int RT_LSB  = 4;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } ifetch_state_e;

endpackage

// File: rtl/opcode_legal_chk.sv
// Combinational opcode legality check, shared by the fetch unit and any
// decode-side checker that needs the same legal-opcode set.
module opcode_legal_chk
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       legal
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    legal = 1'b0;
    case (opcode)
      OP_ADD, OP_LW, OP_SW, OP_SUBI, OP_OR, OP_NOR: legal = 1'b1;
      default:                                      legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/ifetch_issue.sv
// Instruction fetch-and-issue unit: PC, req/ack fetch, field split and
// valid/ready issue. Define IFETCH_RETIRE_CNT_EN to add the retire_cnt output.
module ifetch_issue
  import cpu_pkg::*;
#(
  parameter int AW = 8,
  parameter int IW = 16  // format is fixed; only 16 is meaningful
)
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [3:0]    opcode,
  output logic [3:0]    rs,
  output logic [3:0]    rt,
  output logic [3:0]    imm,
  output logic [AW-1:0] inst_pc,
  output logic          halted,
  output logic          busy
`ifdef IFETCH_RETIRE_CNT_EN
  ,
  output logic [15:0]   retire_cnt
`endif
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_FETCH = FETCH;
  localparam logic [1:0] S_ISSUE = ISSUE;
  localparam logic [1:0] S_HALT  = HALT;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [AW-1:0] pc;
  logic [IW-1:0] ir;
  logic          fetch_legal;
  logic          handshake;

  // Legality is judged on the word arriving with ack, so the FETCH exit
  // can choose ISSUE or HALT in the same cycle the word is captured.
  opcode_legal_chk u_legal_chk (
    .opcode (imem_rdata[OPC_MSB:OPC_LSB]),
    .legal  (fetch_legal)
  );

  assign handshake = (state == S_ISSUE) && inst_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)     state_nxt = S_FETCH;
      S_FETCH: if (imem_ack)  state_nxt = fetch_legal ? S_ISSUE : S_HALT;
      S_ISSUE: if (handshake) state_nxt = stop ? S_IDLE : S_FETCH;
      default:                state_nxt = state;  // HALT: only rst leaves
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && imem_ack) ir <= imem_rdata;
      if (handshake)                    pc <= pc + AW'(1);
    end
  end

`ifdef IFETCH_RETIRE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            retire_cnt <= '0;
    else if (handshake) retire_cnt <= retire_cnt + 16'd1;
  end
`endif

  assign imem_req   = (state == S_FETCH);
  assign imem_addr  = pc;
  assign inst_valid = (state == S_ISSUE);
  assign opcode     = ir[OPC_MSB:OPC_LSB];
  assign rs         = ir[RS_MSB:RS_LSB];
  assign rt         = ir[RT_MSB:RT_LSB];
  assign imm        = ir[IMM_MSB:IMM_LSB];
  assign inst_pc    = pc;
  assign halted     = (state == S_HALT);
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_ifetch_issue.sv
// Self-checking bench for ifetch_issue: directed steps plus a randomized
// run checked against an instruction-level model of the fetch/issue stream.
module tb_ifetch_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [3:0]  opcode, rs, rt, imm;
  logic [7:0]  inst_pc;
  logic        halted, busy;
`ifdef IFETCH_RETIRE_CNT_EN
  logic [15:0] retire_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int exp_retire = 0;

  logic [15:0] mem [256];

  // Memory responder: ack after a configurable number of wait cycles.
  bit          resp_en = 1'b1;
  bit          lat_rand = 1'b0;
  int          lat_fix = 0;
  int          cur_lat = 0;
  int          wait_cnt = 0;
  logic        resp_ack = 1'b0;
  logic [15:0] resp_data = '0;
  logic        man_ack = 1'b0;
  logic [15:0] man_data = '0;

  assign imem_ack   = resp_ack | man_ack;
  assign imem_rdata = man_ack ? man_data : resp_data;

  ifetch_issue #(.AW(8), .IW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .opcode     (opcode),
    .rs         (rs),
    .rt         (rt),
    .imm        (imm),
    .inst_pc    (inst_pc),
    .halted     (halted),
    .busy       (busy)
`ifdef IFETCH_RETIRE_CNT_EN
    ,
    .retire_cnt (retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (resp_en && imem_req) begin
      if (wait_cnt >= cur_lat) begin
        resp_ack  = 1'b1;
        resp_data = mem[imem_addr];
        wait_cnt  = 0;
      end else begin
        resp_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      resp_ack = 1'b0;
      wait_cnt = 0;
      cur_lat  = lat_rand ? int'($urandom_range(0, 3)) : lat_fix;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_retire(input string tag);
`ifdef IFETCH_RETIRE_CNT_EN
    check(tag, 32'(retire_cnt), 32'(exp_retire[15:0]));
`endif
  endtask

  task automatic check_fields(input string tag, input logic [7:0] pc_e);
    logic [15:0] w;
    w = mem[pc_e];
    check({tag, "_opcode"}, 32'(opcode), 32'(w[15:12]));
    check({tag, "_rs"},     32'(rs),     32'(w[11:8]));
    check({tag, "_rt"},     32'(rt),     32'(w[7:4]));
    check({tag, "_imm"},    32'(imm),    32'(w[3:0]));
    check({tag, "_pc"},     32'(inst_pc), 32'(pc_e));
  endtask

  // Fetch and issue the instruction at pc_e; entered in the FETCH cycle.
  task automatic issue_one(input logic [7:0] pc_e, input bit stp, input bit rnd);
    bit done;
    done = 1'b0;
    stop = stp;
    for (int c = 0; c < 64 && !done; c++) begin
      inst_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (imem_req) check("fetch_addr", 32'(imem_addr), 32'(pc_e));
      if (inst_valid) begin
        check_fields("issue", pc_e);
        if (inst_ready) begin
          done = 1'b1;
          exp_retire++;
        end
      end
      step();
    end
    if (!done) check("issue_timeout", 32'(done), 32'd1);
  endtask

  logic [3:0]  legal_ops [6];
  logic [15:0] rw;
  int          req_cycles;

  initial begin
    legal_ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'hF};
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0] = 16'h0123;
    mem[1] = 16'h1456;
    mem[2] = 16'hA000;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_opcode", 32'({opcode, rs, rt, imm}), 32'd0);
    check("rst_pc", 32'(inst_pc), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check_retire("rst_retire");
    rst = 1'b0;
    step();

    // Zero-wait back-to-back issue of addresses 0 and 1
    lat_fix = 0;
    pulse_start();
    check("b_fetch0_req", 32'(imem_req), 32'd1);
    check("b_fetch0_addr", 32'(imem_addr), 32'd0);
    check("b_fetch0_valid", 32'(inst_valid), 32'd0);
    step();
    check("b_issue0_valid", 32'(inst_valid), 32'd1);
    check("b_issue0_req", 32'(imem_req), 32'd0);
    check_fields("b_issue0", 8'd0);
    exp_retire++;
    step();
    check("b_fetch1_req", 32'(imem_req), 32'd1);
    check("b_fetch1_addr", 32'(imem_addr), 32'd1);
    check("b_fetch1_valid", 32'(inst_valid), 32'd0);
    stop = 1'b1;
    step();
    check("b_issue1_valid", 32'(inst_valid), 32'd1);
    check_fields("b_issue1", 8'd1);
    exp_retire++;
    step();
    stop = 1'b0;
    check("b_idle_busy", 32'(busy), 32'd0);
    check("b_idle_pc", 32'(inst_pc), 32'd2);
    check_retire("b_retire2");

    // Illegal word at address 2 halts; start afterwards is ignored
    pulse_start();
    check("h_fetch_addr", 32'(imem_addr), 32'd2);
    step();
    for (int c = 0; c < 6; c++) begin
      if (c == 2) start = 1'b1;
      if (c == 3) start = 1'b0;
      check("h_halted", 32'(halted), 32'd1);
      check("h_valid", 32'(inst_valid), 32'd0);
      check("h_req", 32'(imem_req), 32'd0);
      check("h_pc", 32'(inst_pc), 32'd2);
      check("h_busy", 32'(busy), 32'd1);
      step();
    end
    check_retire("h_retire");

    // Reset clears the halt; then reset mid-FETCH and a late ack is ignored
    rst = 1'b1;
    #1;
    check("r_halted", 32'(halted), 32'd0);
    check("r_opcode", 32'(opcode), 32'd0);
    exp_retire = 0;
    step();
    rst = 1'b0;
    lat_fix = 10;
    step();
    pulse_start();
    check("r_fetch_req", 32'(imem_req), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("r_mid_req", 32'(imem_req), 32'd0);
    check("r_mid_busy", 32'(busy), 32'd0);
    check("r_mid_pc", 32'(inst_pc), 32'd0);
    check_retire("r_retire0");
    step();
    rst = 1'b0;
    resp_en = 1'b0;
    man_data = 16'h0123;
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    check("r_ack_busy", 32'(busy), 32'd0);
    check("r_ack_valid", 32'(inst_valid), 32'd0);
    check("r_ack_opcode", 32'({opcode, rs, rt, imm}), 32'd0);
    step();
    check("r_ack_busy2", 32'(busy), 32'd0);
    resp_en = 1'b1;

    // Ack in the third request cycle, then ready held low for 5 cycles
    lat_fix = 2;
    inst_ready = 1'b0;
    step();
    pulse_start();
    req_cycles = 0;
    for (int c = 0; c < 16 && !inst_valid; c++) begin
      if (imem_req) begin
        req_cycles++;
        check("l_addr_stable", 32'(imem_addr), 32'd0);
      end
      step();
    end
    check("l_req_cycles", 32'(req_cycles), 32'd3);
    for (int c = 0; c < 5; c++) begin
      check("l_stall_valid", 32'(inst_valid), 32'd1);
      check("l_stall_req", 32'(imem_req), 32'd0);
      check_fields("l_stall", 8'd0);
      step();
    end
    inst_ready = 1'b1;
    stop = 1'b1;
    step();
    exp_retire++;
    stop = 1'b0;
    check("l_after_busy", 32'(busy), 32'd0);
    check("l_after_pc", 32'(inst_pc), 32'd1);

    // Random legal program from 1 to 0xFF, stop at 0xFF, pc wraps to 0
    for (int i = 1; i < 256; i++) begin
      rw = 16'($urandom);
      rw[15:12] = legal_ops[$urandom_range(0, 5)];
      mem[i] = rw;
    end
    lat_rand = 1'b1;
    pulse_start();
    for (int p = 1; p < 256; p++) issue_one(8'(p), p == 255, 1'b1);
    stop = 1'b0;
    inst_ready = 1'b1;
    check("w_busy", 32'(busy), 32'd0);
    check("w_pc_wrap", 32'(inst_pc), 32'd0);
    check("w_valid", 32'(inst_valid), 32'd0);
    check_retire("w_retire");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
